// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin scheduler that shares the Common Data Bus among
// NUM_REQ functional-unit result FIFOs. One FIFO is popped per cycle and the
// popped head entry is registered onto the CDB on the following edge.
//
// Bit ordering: fifo_empty, fifo_r_en and fifo_dout are declared with
// ascending ranges, so requester 0 sits in the most-significant position.
// Requester i's entry in fifo_dout is bits [i*WIDTH : i*WIDTH+WIDTH-1].

module cdb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 38,
  localparam int SRC_W  = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [0:NUM_REQ-1]     fifo_empty,
  input  logic [0:NUM_REQ*WIDTH-1] fifo_dout,
  output logic [0:NUM_REQ-1]     fifo_r_en,
  input  logic                   cdb_stall,
  input  logic                   flush,
  output logic                   cdb_valid,
  output logic [WIDTH-1:0]       cdb_data,
  output logic [SRC_W-1:0]       cdb_src
);

  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             cdb_valid_q, cdb_valid_d;
  logic [WIDTH-1:0] cdb_data_q, cdb_data_d;
  logic [SRC_W-1:0] cdb_src_q, cdb_src_d;

  logic             grant_vld;
  logic [SRC_W-1:0] grant_idx;
  logic [WIDTH-1:0] grant_data;

  // Cyclic priority search starting at rr_ptr. The loop runs from the
  // farthest offset down to offset 0 so the nearest requester wins.
  always_comb begin
    logic [SRC_W:0]   sum;
    logic [SRC_W-1:0] idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    sum       = '0;
    idx       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr_q} + (SRC_W+1)'(k);
      // Explicit wrap: NUM_REQ need not be a power of two.
      if (sum >= (SRC_W+1)'(NUM_REQ)) begin
        sum = sum - (SRC_W+1)'(NUM_REQ);
      end
      idx = sum[SRC_W-1:0];
      if (!fifo_empty[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
  end

  // Select the granted FIFO's head entry.
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == SRC_W'(i)) begin
        grant_data = fifo_dout[i*WIDTH +: WIDTH];
      end
    end
  end

  // Pop strobe and next-state: reset > flush > stall > normal.
  always_comb begin
    fifo_r_en   = '0;
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = cdb_valid_q;
    cdb_data_d  = cdb_data_q;
    cdb_src_d   = cdb_src_q;
    if (reset) begin
      fifo_r_en = '0;
    end else if (flush) begin
      cdb_valid_d = 1'b0;
    end else if (cdb_stall) begin
      // hold everything so the presented entry stays on the bus
    end else if (grant_vld) begin
      fifo_r_en[grant_idx] = 1'b1;
      cdb_valid_d          = 1'b1;
      cdb_data_d           = grant_data;
      cdb_src_d            = grant_idx;
      if (grant_idx == SRC_W'(NUM_REQ - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = grant_idx + SRC_W'(1);
      end
    end else begin
      cdb_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_data_q  <= cdb_data_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_src   = cdb_src_q;

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Round-robin scheduler that shares the Common Data Bus (CDB) among NUM_REQ functional-unit result queues. Each queue is a sync FIFO with asynchronous read and synchronous pop.
- Each cycle the arbiter picks at most one non-empty queue and pops it by asserting that queue's r_en.
- It registers the popped entry onto the CDB one cycle later.
- It sits between the functional-unit output FIFOs and the reservation stations / ROB, which snoop the CDB.

Parameters:
NUM_REQ, 4, number of requester FIFOs; must be >= 2.
WIDTH, 38, CDB entry width (6-bit tag + 32-bit data); equals each FIFO's WIDTH.
SRC_W, $clog2(NUM_REQ), width of the source index. Derived localparam, not overridable.

Ports:
clk  input  1  clock; all state updates on posedge.
reset  input  1  synchronous, active-high reset.
fifo_empty  input  NUM_REQ  bit i = empty flag of requester FIFO i.
fifo_dout  input  NUM_REQ*WIDTH  concatenated FIFO head entries. Requester i occupies bits [i*WIDTH : i*WIDTH+WIDTH-1], with bit 0 as MSB.
fifo_r_en  output  NUM_REQ  one-hot or zero pop strobe; bit i drives FIFO i r_en.
cdb_stall  input  1  consumer back-pressure (e.g. ROB cannot accept).
flush  input  1  mispredict/exception flush.
cdb_valid  output  1  CDB carries a valid entry this cycle.
cdb_data  output  WIDTH  registered CDB entry (tag + data).
cdb_src  output  SRC_W  index of the requester that produced cdb_data.

Behaviour:
- Reset (reset=1 at posedge):
  - cdb_valid=0, cdb_data=0, cdb_src=0, rr_ptr=0.
  - fifo_r_en is forced to 0 combinationally whenever reset=1.
- rr_ptr is an internal SRC_W-bit register holding the highest-priority requester index.
- Arbitration is combinational each cycle. Request vector req[i] = !fifo_empty[i].
  - Grant g = first i with req[i]=1, searching cyclically rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ..., rr_ptr-1.
  - If no req bit is set, there is no grant.
- Cycle behaviour is decided by control inputs. Priority order: reset > flush > cdb_stall > normal.
- Normal (flush=0, cdb_stall=0), with a grant:
  - fifo_r_en[g]=1, all other bits 0.
  - At posedge: cdb_data <= slice g of fifo_dout, cdb_src <= g, cdb_valid <= 1.
  - rr_ptr <= (g+1) mod NUM_REQ. Wrap is explicit, since NUM_REQ need not be a power of 2.
- Normal, with no grant:
  - fifo_r_en=0.
  - At posedge: cdb_valid <= 0; cdb_data and cdb_src hold; rr_ptr holds.
- Stall (cdb_stall=1, flush=0):
  - fifo_r_en=0.
  - cdb_valid, cdb_data, cdb_src and rr_ptr all hold, so a presented entry stays on the CDB until the stall releases.
  - No entry is ever lost or duplicated.
- Flush (flush=1, regardless of cdb_stall):
  - fifo_r_en=0.
  - At posedge: cdb_valid <= 0; rr_ptr holds; cdb_data and cdb_src hold.
  - FIFO contents are not touched; the FIFOs are flushed by their own reset path.
- Latency: entry at a FIFO head at cycle t (FIFO non-empty, granted) appears on the CDB with cdb_valid=1 in cycle t+1.
- Throughput: one entry per cycle while any FIFO is non-empty and there is no stall/flush.
- fifo_r_en is never asserted for a FIFO whose fifo_empty=1, so FIFO r_fail must never assert.
- fifo_r_en is at most one-hot in every cycle.
- Fairness: with all NUM_REQ FIFOs continuously non-empty and no stall, grants rotate 0,1,...,NUM_REQ-1,0,...
  - Any continuously requesting FIFO is granted within NUM_REQ unstalled cycles.
- Reset mid-operation: all registered outputs and rr_ptr return to reset values at the next posedge. Any pending pop that cycle is suppressed.

Test Plan:
- Reset, all FIFOs empty for 5 cycles -> fifo_r_en=0, cdb_valid=0, cdb_src=0, cdb_data=0 throughout.
- NUM_REQ=4, FIFOs 0-3 each preloaded with 3 entries (value = 0x100*i + k), no stall -> 12 consecutive cdb_valid cycles, cdb_src sequence 0,1,2,3,0,1,2,3,0,1,2,3, data in per-FIFO order, then cdb_valid=0.
- Only FIFO 2 non-empty with 1 entry, rr_ptr=3 -> fifo_r_en=4'b0010 (bit 2, MSB-first), next cycle cdb_src=2, rr_ptr=3. Next request from FIFO 3 is granted before FIFO 2.
- cdb_stall held high 4 cycles while CDB shows entry from FIFO 1 -> cdb_valid/cdb_data/cdb_src unchanged and fifo_r_en=0 for all 4 cycles. After release the next pop comes from FIFO 2 (if non-empty), and no entry is duplicated or dropped (scoreboard count matches).
- flush asserted together with cdb_stall while valid -> next cycle cdb_valid=0, fifo_r_en=0, FIFO occupancy unchanged. After deassert, arbitration resumes from the held rr_ptr.
- Random push traffic into 4 FIFOs plus random stall/flush, 10k cycles -> no FIFO r_fail, fifo_r_en never more than one-hot, every non-flushed entry seen on CDB exactly once in per-FIFO order, max wait <= 4 unstalled cycles.
